imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator: the successor to the single-cycle extender.
//  Takes instr[31:7] plus a 3-bit format select and returns the sign- or zero-extended
//  immediate at XLEN bits, behind a valid/ready handshake with a 2-entry skid buffer.
//  Sits between decode and execute in the pipelined core; stalls propagate without bubbles.
// PARAMETERS
//  XLEN        32  output width; legal values 32 or 64
//  ILLEGAL_ZERO 1  1: illegal ImmSrc drives data 0; 0: data holds last legal value
// PORTS
//  clk        in   1     rising-edge clock
//  reset_n    in   1     asynchronous, active-low reset
//  in_valid   in   1     upstream item present
//  in_ready   out  1     block can accept an item this cycle
//  in_instr   in   25    instr[31:7]
//  ImmSrc     in   3     format: 000 I,001 S,010 B,011 J,100 U,101 Z(CSR zimm),11x illegal
//  out_valid  out  1     out_imm valid
//  out_ready  in   1     downstream accepts
//  out_imm    out  XLEN  extended immediate
//  out_illegal out 1     item carried an illegal ImmSrc
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_imm=0, out_illegal=0, in_ready=1,
//    skid empty. Reset mid-transfer discards both held items; no partial output.
//  - Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
//  - Latency 1 cycle: item accepted at edge N appears on out_* after edge N (cycle N+1).
//  - Storage: main output register + one skid register. in_ready = !skid_full (registered).
//    Main empty or draining -> accepted item goes to main. Main held (out_valid&!out_ready)
//    -> accepted item goes to skid; in_ready drops next cycle. When main drains, skid
//    moves to main same edge; a simultaneous new input is accepted only if in_ready was 1.
//  - Simultaneous accept+drain with skid empty: main reloads; out_valid stays 1 (no bubble).
//  - out_* stable while out_valid&!out_ready. Throughput 1 item/cycle.
//  - Formats (i = in_instr, bit i[k] = instr[k+7]; sign bit s = i[24]):
//    I {s*,i[24:13]}; S {s*,i[24:18],i[4:0]}; B {s*,i[0],i[23:18],i[4:1],0};
//    J {s*,i[12:5],i[13],i[23:14],0}; U {s*(XLEN-32),i[24:5],12'b0}; Z zero-ext i[12:8].
//    s* = sign replication to XLEN. For XLEN=64 U sign-extends from bit 31.
//  - Illegal 11x: out_illegal=1; out_imm per ILLEGAL_ZERO; item still flows/handshakes.
//  - Extension logic is pure combinational on the input side; only results are registered.
// STRUCTURE
//  - Package imm_pkg: ImmSrc localparams (IMM_I..IMM_Z), format width constant (3).
//  - Sub-module imm_decode (combinational: instr, ImmSrc -> imm, illegal; XLEN param),
//    instantiated once ahead of the skid/output registers.
// TESTING
//  - Reset: hold reset_n=0 with in_valid=1 -> out_valid=0,out_imm=0,in_ready=1; release
//    -> first item appears 1 cycle after acceptance.
//  - Formats XLEN=32, out_ready=1: I in=1FFE001 -> FFFFFFFF; U in=02468A0 -> 12345000;
//    J in=1FFBFE0 -> FFFFFFFC; B in=0000008 -> 00000008; each 1-cycle latency.
//  - XLEN=64: I in=1FFE001 -> FFFFFFFFFFFFFFFF; U in=02468A0 -> 0000000012345000.
//  - Backpressure: stream 4 items, out_ready=0 for 3 cycles -> main+skid fill, in_ready=0
//    from 2nd held cycle, no item lost/duplicated, order preserved after out_ready=1.
//  - Illegal: ImmSrc=110 -> out_illegal=1, out_imm=0 (ILLEGAL_ZERO=1); next legal item
//    clears out_illegal.
//  - Async reset asserted while skid full -> all outputs to reset values same cycle.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the pipelined immediate generator: format select codes and width.
// No logic, so there is no latency and no backpressure here.
// Codes 3'b110 and 3'b111 are reserved, and the decoder reports them as illegal.
package imm_pkg;
    localparam int         IMM_SEL_W = 3;
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_Z     = 3'b101;
endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from instr[31:7] for the I/S/B/J/U/Z formats.
// Latency 0: this block is pure logic and holds no state.
// No backpressure: the result follows the inputs every cycle.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]          instr,
    input  logic [IMM_SEL_W-1:0] sel,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);
    logic        s;
    logic [31:0] imm32;

    assign s = instr[24];

    // Every format is built at 32 bits first. For XLEN=64, the extension below copies
    // bit 31 upward. Z keeps bit 31 clear, so Z is zero-extended.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (sel)
            IMM_I:   imm32 = {{20{s}}, instr[24:13]};
            IMM_S:   imm32 = {{20{s}}, instr[24:18], instr[4:0]};
            IMM_B:   imm32 = {{20{s}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:   imm32 = {{12{s}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_U:   imm32 = {instr[24:5], 12'b0};
            IMM_Z:   imm32 = {27'b0, instr[12:8]};
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes and extends the immediate, then drives it through an output register and a skid register.
// Latency 1 cycle. Throughput is 1 item per cycle, with no bubble when the output drains.
// Backpressure: a stalled output sends the next item to the skid register. in_ready is the registered !skid_full.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [24:0]          in_instr,
    input  logic [IMM_SEL_W-1:0] ImmSrc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_illegal
);
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] new_imm;
    logic [XLEN-1:0] last_legal;
    logic [XLEN-1:0] skid_imm;
    logic            dec_ill;
    logic            skid_vld;
    logic            skid_ill;
    logic            accept;
    logic            main_free;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .sel     (ImmSrc),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign new_imm   = dec_ill ? (ILLEGAL_ZERO ? '0 : last_legal) : dec_imm;
    assign in_ready  = !skid_vld;
    assign accept    = in_valid && in_ready;
    assign main_free = !out_valid || out_ready;

    // While the skid holds an item, in_ready is low, so accept can't be high at the same time as skid-to-main.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            skid_vld    <= 1'b0;
            skid_imm    <= '0;
            skid_ill    <= 1'b0;
            last_legal  <= '0;
        end else begin
            if (accept && !dec_ill) begin
                last_legal <= dec_imm;
            end
            if (main_free) begin
                if (skid_vld) begin
                    out_valid   <= 1'b1;
                    out_imm     <= skid_imm;
                    out_illegal <= skid_ill;
                    skid_vld    <= 1'b0;
                end else if (accept) begin
                    out_valid   <= 1'b1;
                    out_imm     <= new_imm;
                    out_illegal <= dec_ill;
                end else begin
                    out_valid   <= 1'b0;
                end
            end else if (accept) begin
                skid_vld <= 1'b1;
                skid_imm <= new_imm;
                skid_ill <= dec_ill;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe. It uses an XLEN=32 zeroing instance and an XLEN=64 hold-last instance, both on the same stimulus.
// The expected values come from an in-order queue of RISC-V immediates decoded from the full instruction word.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  ImmSrc;
    logic        out_ready;
    logic        in_ready32, out_valid32, out_illegal32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [63:0] last64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .ILLEGAL_ZERO(1'b1)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .ImmSrc(ImmSrc), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .ILLEGAL_ZERO(1'b0)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .ImmSrc(ImmSrc), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_illegal(out_illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] x, input int w);
        logic signed [63:0] t;
        t = $signed(x << (64 - w));
        return t >>> (64 - w);
    endfunction

    // RISC-V immediate, taken from the fields of the whole 32-bit instruction.
    function automatic logic [63:0] ref_imm(input logic [24:0] f, input logic [2:0] sel);
        logic [31:0] w;
        w = {f, 7'b0};
        case (sel)
            3'd0:    return sext(64'(w[31:20]), 12);
            3'd1:    return sext(64'({w[31:25], w[11:7]}), 12);
            3'd2:    return sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
            3'd3:    return sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
            3'd4:    return sext(64'({w[31:12], 12'b0}), 32);
            3'd5:    return 64'(w[19:15]);
            default: return 64'd0;
        endcase
    endfunction

    // Check the handshake signals and the queue head between edges, then update the model at the edge.
    task automatic tick(output bit acc);
        bit          drn;
        exp_t        ex;
        logic [63:0] full;
        @(negedge clk);
        chk("in_ready32", 64'(in_ready32), 64'(reset_n ? (q.size() < 2) : 1'b1));
        chk("in_ready64", 64'(in_ready64), 64'(reset_n ? (q.size() < 2) : 1'b1));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_imm32", 64'(out_imm32), q[0].e32);
            chk("out_imm64", out_imm64, q[0].e64);
            chk("out_illegal32", 64'(out_illegal32), 64'(q[0].ill));
            chk("out_illegal64", 64'(out_illegal64), 64'(q[0].ill));
        end
        acc = reset_n && in_valid && (q.size() < 2);
        drn = reset_n && out_ready && (q.size() != 0);
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) begin
            full   = ref_imm(in_instr, ImmSrc);
            ex.ill = (ImmSrc >= 3'd6);
            ex.e32 = ex.ill ? 64'd0 : 64'(full[31:0]);
            ex.e64 = ex.ill ? last64 : full;
            if (!ex.ill) last64 = full;
            q.push_back(ex);
        end
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld32"}, 64'(out_valid32), 64'd0);
        chk({tag, "_vld64"}, 64'(out_valid64), 64'd0);
        chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
        chk({tag, "_imm64"}, out_imm64, 64'd0);
        chk({tag, "_ill32"}, 64'(out_illegal32), 64'd0);
        chk({tag, "_rdy32"}, 64'(in_ready32), 64'd1);
        chk({tag, "_rdy64"}, 64'(in_ready64), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int cnt;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 25'h1FFE001;
        ImmSrc    = 3'b000;
        out_ready = 1'b1;
        last64    = '0;

        // Hold reset while in_valid is high. The outputs must stay at their reset values.
        repeat (3) tick(acc);
        chk_reset_vals("rst_hold");
        reset_n = 1'b1;

        // Each directed format test accepts at one edge and checks the result just after that edge.
        in_instr = 25'h1FFE001; ImmSrc = 3'b000; tick(acc);
        chk("I_vld", 64'(out_valid32), 64'd1);
        chk("I_32", 64'(out_imm32), 64'hFFFFFFFF);
        chk("I_64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        in_instr = 25'h02468A0; ImmSrc = 3'b100; tick(acc);
        chk("U_32", 64'(out_imm32), 64'h12345000);
        chk("U_64", out_imm64, 64'h0000000012345000);
        in_instr = 25'h1FFBFE0; ImmSrc = 3'b011; tick(acc);
        chk("J_32", 64'(out_imm32), 64'hFFFFFFFC);
        in_instr = 25'h0000008; ImmSrc = 3'b010; tick(acc);
        chk("B_32", 64'(out_imm32), 64'h00000008);

        // An illegal select zeros the 32-bit instance and makes the 64-bit instance hold B's value.
        in_instr = 25'h1234567; ImmSrc = 3'b110; tick(acc);
        chk("ill_flag", 64'(out_illegal32), 64'd1);
        chk("ill_imm32", 64'(out_imm32), 64'd0);
        chk("ill_imm64", out_imm64, 64'd8);
        in_instr = 25'h0000ABC; ImmSrc = 3'b001; tick(acc);
        chk("ill_clear", 64'(out_illegal32), 64'd0);
        in_valid = 1'b0; tick(acc); tick(acc);

        // Backpressure: send 4 items while out_ready is low for the first 3 cycles.
        cnt = 0;
        in_valid = 1'b1; in_instr = 25'($urandom); ImmSrc = 3'($urandom_range(0, 5));
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 3);
            tick(acc);
            if (acc) begin
                cnt++;
                in_instr = 25'($urandom); ImmSrc = 3'($urandom_range(0, 5));
                if (cnt == 4) in_valid = 1'b0;
            end
            if (c == 1) chk("bp_rdy_low", 64'(in_ready32), 64'd0);
        end
        chk("bp_all_accepted", 64'(cnt), 64'd4);
        chk("bp_all_drained", 64'(q.size()), 64'd0);

        // Fill the main and skid registers, then assert reset in the middle of the cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        tick(acc); in_instr = 25'h0ABCDEF; tick(acc);
        chk("skid_full", 64'(in_ready32), 64'd0);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rst_async");
        q.delete(); last64 = '0;
        in_valid = 1'b0; tick(acc); tick(acc);
        reset_n = 1'b1; out_ready = 1'b1;

        // Random traffic and random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = 25'($urandom);
            ImmSrc    = 3'($urandom_range(0, 7));
            tick(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick(acc);
        chk("final_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
